// File: rtl/ddr3_app_master.sv
// Burst-less DDR3 MIG application-port master: turns a (addr, len, dir) request into
// single-beat app_* commands plus the matching write-data / read-data streams.
module ddr3_app_master #(
  parameter int unsigned ADDR_STEP = 8,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             ui_clk,
  input  logic             ui_clk_sync_rst,
  input  logic             init_calib_complete,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [27:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic [27:0]      app_addr,
  output logic [2:0]       app_cmd,
  output logic             app_en,
  input  logic             app_rdy,
  output logic [31:0]      app_wdf_data,
  output logic             app_wdf_wren,
  output logic             app_wdf_end,
  output logic [3:0]       app_wdf_mask,
  input  logic             app_wdf_rdy,
  input  logic [31:0]      app_rd_data,
  input  logic             app_rd_data_valid,
  input  logic             app_rd_data_end
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e           state_q;
  logic [27:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic             write_q;
  logic [LEN_W-1:0] cmd_cnt_q;
  logic [LEN_W-1:0] dat_cnt_q;
  logic [LEN_W-1:0] rd_cnt_q;
  logic [31:0]      rd_data_q;
  logic             rd_valid_q;

  logic             in_write;
  logic             in_read;
  logic             dat_room;
  logic             cmd_fire;
  logic             dat_fire;
  logic [LEN_W-1:0] cmd_cnt_nxt;
  logic [LEN_W-1:0] dat_cnt_nxt;
  logic [LEN_W-1:0] rd_cnt_nxt;
  logic             unused_rd_end;

  // Read bursts are single-beat, so the end marker carries no extra information.
  assign unused_rd_end = app_rd_data_end;

  assign in_write = (state_q == StWrite);
  assign in_read  = (state_q == StRead);
  assign dat_room = (dat_cnt_q < len_q);

  assign req_ready = (state_q == StIdle) && init_calib_complete && !ui_clk_sync_rst;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  assign wr_ready     = in_write && app_wdf_rdy && dat_room;
  assign app_wdf_wren = in_write && wr_valid && dat_room;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = wr_data;
  assign app_wdf_mask = 4'h0;

  // Writes never let a command lead its data; reads issue freely up to len.
  assign app_en   = (in_write && (cmd_cnt_q < dat_cnt_q)) || (in_read && (cmd_cnt_q < len_q));
  assign app_cmd  = (app_en && !write_q) ? 3'b001 : 3'b000;
  assign app_addr = addr_q + 28'(cmd_cnt_q) * 28'(ADDR_STEP);

  assign cmd_fire    = app_en && app_rdy;
  assign dat_fire    = app_wdf_wren && app_wdf_rdy;
  assign cmd_cnt_nxt = cmd_cnt_q + LEN_W'(cmd_fire);
  assign dat_cnt_nxt = dat_cnt_q + LEN_W'(dat_fire);
  assign rd_cnt_nxt  = rd_cnt_q + LEN_W'(1);

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      write_q    <= 1'b0;
      cmd_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      // The final read beat is captured in READ and shows up during the DONE cycle.
      rd_valid_q <= in_read && app_rd_data_valid;
      if (in_read && app_rd_data_valid) begin
        rd_data_q <= app_rd_data;
      end

      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            len_q     <= req_len;
            write_q   <= req_write;
            cmd_cnt_q <= '0;
            dat_cnt_q <= '0;
            rd_cnt_q  <= '0;
            if (req_len == '0) begin
              state_q <= StDone;
            end else if (req_write) begin
              state_q <= StWrite;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StWrite: begin
          cmd_cnt_q <= cmd_cnt_nxt;
          dat_cnt_q <= dat_cnt_nxt;
          if ((cmd_cnt_nxt == len_q) && (dat_cnt_nxt == len_q)) begin
            state_q <= StDone;
          end
        end
        StRead: begin
          cmd_cnt_q <= cmd_cnt_nxt;
          if (app_rd_data_valid) begin
            rd_cnt_q <= rd_cnt_nxt;
            if (rd_cnt_nxt == len_q) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_app_master.sv
// Directed bench for ddr3_app_master with a small MIG-like responder (delayed read returns).
module tb_ddr3_app_master;

  localparam int unsigned LEN_W = 16;

  logic             ui_clk = 1'b0;
  logic             ui_clk_sync_rst;
  logic             init_calib_complete;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [27:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic [31:0]      wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic [27:0]      app_addr;
  logic [2:0]       app_cmd;
  logic             app_en;
  logic             app_rdy;
  logic [31:0]      app_wdf_data;
  logic             app_wdf_wren;
  logic             app_wdf_end;
  logic [3:0]       app_wdf_mask;
  logic             app_wdf_rdy;
  logic [31:0]      app_rd_data;
  logic             app_rd_data_valid;
  logic             app_rd_data_end;

  always #5 ui_clk = ~ui_clk;

  ddr3_app_master #(
    .ADDR_STEP(8),
    .LEN_W    (LEN_W)
  ) dut (
    .ui_clk             (ui_clk),
    .ui_clk_sync_rst    (ui_clk_sync_rst),
    .init_calib_complete(init_calib_complete),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_addr           (req_addr),
    .req_len            (req_len),
    .wr_data            (wr_data),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .rd_data            (rd_data),
    .rd_valid           (rd_valid),
    .busy               (busy),
    .done               (done),
    .app_addr           (app_addr),
    .app_cmd            (app_cmd),
    .app_en             (app_en),
    .app_rdy            (app_rdy),
    .app_wdf_data       (app_wdf_data),
    .app_wdf_wren       (app_wdf_wren),
    .app_wdf_end        (app_wdf_end),
    .app_wdf_mask       (app_wdf_mask),
    .app_wdf_rdy        (app_wdf_rdy),
    .app_rd_data        (app_rd_data),
    .app_rd_data_valid  (app_rd_data_valid),
    .app_rd_data_end    (app_rd_data_end)
  );

  int checks   = 0;
  int failures = 0;

  // Bench-controlled knobs (written by the main thread only).
  bit         rdy_toggle = 1'b0;
  bit         wr_mode    = 1'b0;
  int         starve_at  = -1;
  logic [2:0] exp_cmd    = 3'b000;
  int         acc_cyc    = 0;

  // Responder/monitor state (written by the responder only).
  int          cyc         = 0;
  int          wbeat       = 0;
  int          starve_left = 0;
  int          starve_fired = -1;
  int          starve_en   = 0;
  int          cmd_err     = 0;
  int          hold_err    = 0;
  int          frame_err   = 0;
  int          en_cyc      = 0;
  int          wr_hs       = 0;
  int          done_cnt    = 0;
  int          done_cyc    = -1;
  int          last_rd_cyc = -1;
  bit          prev_stall  = 1'b0;
  logic [27:0] prev_addr   = '0;
  logic [2:0]  prev_cmd    = '0;
  logic [27:0] cmd_log[$];
  logic [31:0] wdat_log[$];
  logic [31:0] rd_log[$];
  int          due_q[$];
  logic [31:0] ret_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive on the falling edge, observe 1 time unit later, well away from the rising edge.
  initial begin
    app_rdy           = 1'b1;
    app_wdf_rdy       = 1'b1;
    wr_valid          = 1'b0;
    wr_data           = '0;
    app_rd_data       = '0;
    app_rd_data_valid = 1'b0;
    app_rd_data_end   = 1'b0;
    forever begin
      @(negedge ui_clk);
      cyc++;
      app_rdy = rdy_toggle ? cyc[0] : 1'b1;
      if (starve_at >= 0 && wbeat == starve_at && starve_fired != starve_at) begin
        starve_left  = 5;
        starve_fired = starve_at;
      end
      wr_valid = wr_mode && (starve_left == 0);
      wr_data  = 32'hD000_0000 + 32'(wbeat);
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data_end   = 1'b1;
        app_rd_data       = ret_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        app_rd_data_valid = 1'b0;
        app_rd_data_end   = 1'b0;
        app_rd_data       = '0;
      end
      #1;
      if (ui_clk_sync_rst) begin
        due_q.delete();
        ret_q.delete();
      end
      if (app_en && app_rdy) begin
        cmd_log.push_back(app_addr);
        if (app_cmd == 3'b001) begin
          due_q.push_back(cyc + 10);
          ret_q.push_back({4'hA, app_addr});
        end
      end
      if (app_en) begin
        en_cyc++;
        if (app_cmd != exp_cmd) cmd_err++;
      end else if (app_cmd != 3'b000) begin
        cmd_err++;
      end
      if (prev_stall && (!app_en || app_addr != prev_addr || app_cmd != prev_cmd)) hold_err++;
      prev_stall = app_en && !app_rdy;
      prev_addr  = app_addr;
      prev_cmd   = app_cmd;
      if (app_wdf_wren && app_wdf_rdy) begin
        wdat_log.push_back(app_wdf_data);
        wbeat++;
        if (!app_wdf_end || app_wdf_mask != 4'h0) frame_err++;
      end
      if (wr_valid && wr_ready) wr_hs++;
      if (rd_valid) begin
        rd_log.push_back(rd_data);
        last_rd_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (starve_left > 0) begin
        if (app_en) starve_en++;
        starve_left--;
      end
    end
  end

  task automatic do_req(input string tag, input logic wr, input logic [27:0] addr,
                        input logic [LEN_W-1:0] len);
    @(negedge ui_clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    #2;
    check_eq(tag, {31'd0, req_ready}, 32'd1);
    acc_cyc = cyc;
    @(negedge ui_clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int s;
    int n;
    s = done_cnt;
    n = 0;
    while (done_cnt == s && n < max_cyc) begin
      @(negedge ui_clk);
      #2;
      n++;
    end
    check_eq(tag, 32'(done_cnt - s), 32'd1);
  endtask

  initial begin
    int cb;
    int wb;
    int hs;
    int d0;
    int rb;
    int se0;
    int e0;
    int n;
    ui_clk_sync_rst     = 1'b1;
    init_calib_complete = 1'b1;
    req_valid           = 1'b0;
    req_write           = 1'b0;
    req_addr            = '0;
    req_len             = '0;

    // Reset values, with calibration already complete.
    repeat (3) @(negedge ui_clk);
    #2;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_app_en", {31'd0, app_en}, 32'd0);
    check_eq("rst_wren", {30'd0, app_wdf_wren, app_wdf_end}, 32'd0);
    check_eq("rst_app_cmd", {29'd0, app_cmd}, 32'd0);
    check_eq("rst_app_addr", {4'd0, app_addr}, 32'd0);
    @(negedge ui_clk);
    ui_clk_sync_rst = 1'b0;
    repeat (2) @(negedge ui_clk);

    // Plain write, everything ready.
    exp_cmd = 3'b000;
    wr_mode = 1'b1;
    cb = cmd_log.size();
    wb = wdat_log.size();
    hs = wr_hs;
    d0 = done_cnt;
    do_req("wr_accept", 1'b1, 28'h100, 16'd4);
    wait_done("wr_done", 100);
    repeat (3) @(negedge ui_clk);
    #2;
    check_eq("wr_ncmd", 32'(cmd_log.size() - cb), 32'd4);
    check_eq("wr_addr0", {4'd0, cmd_log[cb + 0]}, 32'h100);
    check_eq("wr_addr1", {4'd0, cmd_log[cb + 1]}, 32'h108);
    check_eq("wr_addr2", {4'd0, cmd_log[cb + 2]}, 32'h110);
    check_eq("wr_addr3", {4'd0, cmd_log[cb + 3]}, 32'h118);
    check_eq("wr_nbeats", 32'(wdat_log.size() - wb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("wr_data", wdat_log[wb + i], 32'hD000_0000 + 32'(i));
    end
    check_eq("wr_hs", 32'(wr_hs - hs), 32'd4);
    check_eq("wr_one_done", 32'(done_cnt - d0), 32'd1);
    check_eq("wr_idle_busy", {31'd0, busy}, 32'd0);

    // Command-side stall: app_rdy toggling every cycle.
    rdy_toggle = 1'b1;
    cb = cmd_log.size();
    do_req("stall_accept", 1'b1, 28'h200, 16'd5);
    wait_done("stall_done", 200);
    check_eq("stall_ncmd", 32'(cmd_log.size() - cb), 32'd5);
    check_eq("stall_addr0", {4'd0, cmd_log[cb + 0]}, 32'h200);
    check_eq("stall_addr2", {4'd0, cmd_log[cb + 2]}, 32'h210);
    check_eq("stall_addr4", {4'd0, cmd_log[cb + 4]}, 32'h220);
    check_eq("stall_hold", 32'(hold_err), 32'd0);
    rdy_toggle = 1'b0;
    repeat (2) @(negedge ui_clk);

    // Write data starvation after two beats.
    cb  = cmd_log.size();
    hs  = wr_hs;
    se0 = starve_en;
    starve_at = wbeat + 2;
    do_req("starve_accept", 1'b1, 28'h300, 16'd6);
    wait_done("starve_done", 200);
    check_eq("starve_ncmd", 32'(cmd_log.size() - cb), 32'd6);
    check_eq("starve_addr5", {4'd0, cmd_log[cb + 5]}, 32'h328);
    check_eq("starve_en_cycles", 32'(starve_en - se0), 32'd1);
    check_eq("starve_hs", 32'(wr_hs - hs), 32'd6);
    wr_mode = 1'b0;
    repeat (2) @(negedge ui_clk);
    check_eq("no_rd_in_wr", 32'(rd_log.size()), 32'd0);

    // Read with 10-cycle return latency and address wrap.
    exp_cmd = 3'b001;
    cb = cmd_log.size();
    rb = rd_log.size();
    do_req("rd_accept", 1'b0, 28'hFFF_FFF8, 16'd3);
    wait_done("rd_done", 200);
    check_eq("rd_ncmd", 32'(cmd_log.size() - cb), 32'd3);
    check_eq("rd_addr0", {4'd0, cmd_log[cb + 0]}, 32'h0FFF_FFF8);
    check_eq("rd_addr1", {4'd0, cmd_log[cb + 1]}, 32'h0000_0000);
    check_eq("rd_addr2", {4'd0, cmd_log[cb + 2]}, 32'h0000_0008);
    check_eq("rd_nbeats", 32'(rd_log.size() - rb), 32'd3);
    check_eq("rd_data0", rd_log[rb + 0], 32'hAFFF_FFF8);
    check_eq("rd_data1", rd_log[rb + 1], 32'hA000_0000);
    check_eq("rd_data2", rd_log[rb + 2], 32'hA000_0008);
    check_eq("rd_done_with_last", 32'(done_cyc), 32'(last_rd_cyc));
    repeat (2) @(negedge ui_clk);

    // Calibration gating, then a zero-length request.
    @(negedge ui_clk);
    init_calib_complete = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_len   = 16'd5;
    repeat (3) @(negedge ui_clk);
    #2;
    check_eq("gate_req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("gate_busy", {31'd0, busy}, 32'd0);
    req_valid = 1'b0;
    init_calib_complete = 1'b1;
    e0 = en_cyc;
    do_req("len0_accept", 1'b1, 28'h700, 16'd0);
    wait_done("len0_done", 10);
    check_eq("len0_done_cycle", 32'(done_cyc), 32'(acc_cyc + 1));
    check_eq("len0_no_app_en", 32'(en_cyc - e0), 32'd0);
    repeat (2) @(negedge ui_clk);

    // Reset in the middle of an 8-beat read.
    exp_cmd = 3'b001;
    cb = cmd_log.size();
    rb = rd_log.size();
    do_req("mrst_accept", 1'b0, 28'h400, 16'd8);
    n = 0;
    while (cmd_log.size() - cb < 2 && n < 20) begin
      @(negedge ui_clk);
      #2;
      n++;
    end
    check_eq("mrst_two_cmds", {31'd0, (cmd_log.size() - cb) >= 2}, 32'd1);
    @(negedge ui_clk);
    ui_clk_sync_rst = 1'b1;
    #2;
    d0 = done_cnt;
    check_eq("mrst_busy", {31'd0, busy}, 32'd0);
    check_eq("mrst_app_en", {31'd0, app_en}, 32'd0);
    check_eq("mrst_app_addr", {4'd0, app_addr}, 32'd0);
    check_eq("mrst_app_cmd", {29'd0, app_cmd}, 32'd0);
    check_eq("mrst_rd_out", {rd_data[30:0], rd_valid}, 32'd0);
    check_eq("mrst_ready", {29'd0, req_ready, wr_ready, app_wdf_wren}, 32'd0);
    repeat (2) @(negedge ui_clk);
    ui_clk_sync_rst = 1'b0;
    repeat (15) @(negedge ui_clk);
    #2;
    check_eq("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("mrst_no_rd", 32'(rd_log.size() - rb), 32'd0);

    cb = cmd_log.size();
    do_req("post_accept", 1'b0, 28'h500, 16'd2);
    wait_done("post_done", 100);
    check_eq("post_ncmd", 32'(cmd_log.size() - cb), 32'd2);
    check_eq("post_addr1", {4'd0, cmd_log[cb + 1]}, 32'h508);
    check_eq("post_nbeats", 32'(rd_log.size() - rb), 32'd2);
    check_eq("post_data0", rd_log[rb + 0], 32'hA000_0500);
    check_eq("post_data1", rd_log[rb + 1], 32'hA000_0508);

    check_eq("app_cmd_values", 32'(cmd_err), 32'd0);
    check_eq("cmd_hold_total", 32'(hold_err), 32'd0);
    check_eq("wdf_framing", 32'(frame_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ddr3_app_master.md
DDR3_APP_MASTER -- requirements
Module: ddr3_app_master

Interface
REQ-001 Parameter: ADDR_STEP, default 8, app_addr increment per issued command (beat).
REQ-002 Parameter: LEN_W, default 16, width of req_len.
REQ-003 Clocking and reset: one clock, ui_clk; reset ui_clk_sync_rst is asynchronous and active-high.
REQ-004 Ports are listed as name, direction, width, meaning:
- ui_clk, in, 1, sole clock.
- ui_clk_sync_rst, in, 1, asynchronous active-high reset.
- init_calib_complete, in, 1, memory controller ready for traffic.
- req_valid, in, 1, transfer request.
- req_ready, out, 1, request accepted when req_valid and req_ready are both 1.
- req_write, in, 1, 1 = write transfer, 0 = read transfer.
- req_addr, in, 28, start address.
- req_len, in, LEN_W, beat count.
- wr_data, in, 32, write data stream.
- wr_valid, in, 1, write data stream valid.
- wr_ready, out, 1, write data stream ready.
- rd_data, out, 32, read data stream (no backpressure).
- rd_valid, out, 1, read data stream valid.
- busy, out, 1, transfer in progress.
- done, out, 1, one-cycle pulse at transfer completion.
- app_addr, out, 28, controller command address.
- app_cmd, out, 3, controller command.
- app_en, out, 1, command valid.
- app_rdy, in, 1, controller command ready.
- app_wdf_data, out, 32, controller write data.
- app_wdf_wren, out, 1, write data valid.
- app_wdf_end, out, 1, last beat of write data.
- app_wdf_mask, out, 4, write byte mask.
- app_wdf_rdy, in, 1, controller write data ready.
- app_rd_data, in, 32, controller read data.
- app_rd_data_valid, in, 1, read data valid.
- app_rd_data_end, in, 1, last beat of read data.

Function
REQ-005 State machine: IDLE, WRITE, READ, DONE.
REQ-006 req_ready = 1 only in IDLE with init_calib_complete = 1; on acceptance, latch req_addr, req_len and req_write, and clear cmd_cnt, dat_cnt and rd_cnt.
REQ-007 An accepted request goes IDLE->WRITE if req_write = 1, IDLE->READ if req_write = 0, and IDLE->DONE if req_len = 0, with no app_* activity in the req_len = 0 case.
REQ-008 A command is accepted only in a cycle where app_en = 1 and app_rdy = 1; cmd_cnt increments on each accepted command.
REQ-009 While app_en = 1 and app_rdy = 0, app_en, app_addr and app_cmd SHALL hold stable.
REQ-010 app_addr = latched_addr + cmd_cnt*ADDR_STEP, truncated to 28 bits, so the address wraps modulo 2^28.
REQ-011 app_cmd = 3'b000 in WRITE and 3'b001 in READ, and app_cmd = 3'b000 whenever app_en = 0.
REQ-012 WRITE data path: wr_ready = app_wdf_rdy and (dat_cnt < len); app_wdf_wren = wr_valid and (dat_cnt < len); app_wdf_data = wr_data (combinational pass-through); dat_cnt increments on each cycle with app_wdf_wren = 1 and app_wdf_rdy = 1.
REQ-013 WRITE framing: app_wdf_end = app_wdf_wren (one beat per command); app_wdf_mask = 4'h0 at all times.
REQ-014 WRITE command issue: app_en = 1 when cmd_cnt < dat_cnt, so a command never leads its data; data may lead commands by any amount.
REQ-015 WRITE->DONE when cmd_cnt = len and dat_cnt = len, including when both counters reach len in the same cycle.
REQ-016 READ command issue: app_en = 1 while cmd_cnt < len.
REQ-017 READ data path: rd_data = app_rd_data and rd_valid = app_rd_data_valid, registered with 1-cycle latency; rd_cnt increments on each app_rd_data_valid; app_rd_data_end is ignored.
REQ-018 READ->DONE on the cycle the len-th beat is received; the registered final beat appears on rd_valid in the DONE cycle.
REQ-019 DONE lasts exactly one cycle with done = 1, then goes to IDLE; busy = 1 in WRITE, READ and DONE.
REQ-020 app_rd_data_valid while not in READ is ignored and not forwarded, except for the final registered beat of REQ-018.
REQ-021 init_calib_complete deasserting mid-transfer has no effect; it gates only request acceptance.
REQ-022 Counters are LEN_W bits wide, and req_len = 2^LEN_W-1 SHALL complete without counter overflow.

Reset
REQ-023 While ui_clk_sync_rst = 1, the state is IDLE and all counters are 0.
REQ-024 Reset values: req_ready = 0, wr_ready = 0, rd_valid = 0, rd_data = 0, busy = 0, done = 0, app_en = 0, app_wdf_wren = 0, app_wdf_end = 0, app_cmd = 0, app_addr = 0.
REQ-025 Reset asserted mid-transfer aborts immediately with no done pulse, and any outstanding reads are dropped.

Verification
REQ-026 Write beats: req write addr 0x100 len 4, app_rdy and app_wdf_rdy held 1, wr_valid held 1 -> 4 data beats; commands issued at 0x100, 0x108, 0x110, 0x118; done pulses once; wr_ready takes 4 beats.
REQ-027 Write stall: app_rdy toggles 0/1 every cycle during a write -> app_addr and app_en hold while app_rdy = 0; no address is skipped or repeated.
REQ-028 Write data starvation: wr_valid = 0 for 5 cycles mid-write -> app_en drops once cmd_cnt = dat_cnt; the transfer resumes and completes with exactly len commands.
REQ-029 Read: len 3 at addr 0xFFFFFF8 with read data returned 10 cycles late -> addresses 0xFFFFFF8, 0x0000000, 0x0000008; 3 rd_valid pulses carrying the controller data; done follows the third beat.
REQ-030 Gating: init_calib_complete = 0 with req_valid = 1 -> req_ready = 0; req_len = 0 -> done one cycle after acceptance with no app_en.
REQ-031 Mid-transfer reset: reset pulsed during READ after 2 of 8 commands -> all outputs at reset values; a subsequent read request executes normally.
